// File: rtl/sram_ctrl_pkg.sv
// Shared constants and types for the single-port SRAM controller.
package sram_ctrl_pkg;
   localparam int BITS_DEF  = 2;
   localparam int DEPTH_DEF = 64;
   localparam int AW_DEF    = 6;

   typedef logic [1:0] occ_t;

   typedef enum logic {
      GNT_WR = 1'b0,
      GNT_RD = 1'b1
   } gnt_e;
endpackage

// File: rtl/sram_1p_ctrl_if.sv
// Request/response channels and macro pins of the single-port SRAM controller.
interface sram_1p_ctrl_if
   import sram_ctrl_pkg::*;
#(
   parameter int BITS = BITS_DEF,
   parameter int AW   = AW_DEF
);
   logic            wr_valid;
   logic            wr_ready;
   logic [AW-1:0]   wr_addr;
   logic [BITS-1:0] wr_data;
   logic            rd_valid;
   logic            rd_ready;
   logic [AW-1:0]   rd_addr;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [BITS-1:0] rsp_data;
   logic            sram_ceb;
   logic            sram_web;
   logic [AW-1:0]   sram_a;
   logic [BITS-1:0] sram_d;
   logic [BITS-1:0] sram_q;

   modport slave (
      input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rsp_ready, sram_q,
      output wr_ready, rd_ready, rsp_valid, rsp_data, sram_ceb, sram_web, sram_a, sram_d
   );

   modport master (
      output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rsp_ready, sram_q,
      input  wr_ready, rd_ready, rsp_valid, rsp_data, sram_ceb, sram_web, sram_a, sram_d
   );
endinterface

// File: rtl/sram_rsp_fifo2.sv
// Two-entry response FIFO; head data reads as zero while empty.
module sram_rsp_fifo2
   import sram_ctrl_pkg::*;
#(
   parameter int BITS = BITS_DEF
) (
   input  logic            CLK,
   input  logic            RSTB,
   input  logic            push,
   input  logic [BITS-1:0] push_data,
   input  logic            pop,
   output occ_t            occ,
   output logic [BITS-1:0] head_data
);
   logic [BITS-1:0] mem_q [2];
   logic [BITS-1:0] mem_d [2];
   logic            wr_ptr_q, wr_ptr_d;
   logic            rd_ptr_q, rd_ptr_d;
   occ_t            occ_q, occ_d;
   logic            pop_ok;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      pop_ok   = pop & (occ_q != '0);
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop_ok) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop_ok})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   assign occ       = occ_q;
   assign head_data = (occ_q != '0) ? mem_q[rd_ptr_q] : '0;
endmodule

// File: rtl/sram_1p_ctrl.sv
// Single-port SRAM controller: round-robin write/read arbitration onto one macro
// port, with read credit so the 2-entry response buffer can never overflow.
//
// last_gnt | meaning
// GNT_WR   | last contested cycle went to the write side; next contest goes to read
// GNT_RD   | last contested cycle went to the read side; next contest goes to write
module sram_1p_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int BITS  = BITS_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          CLK,
   input  logic          RSTB,
   sram_1p_ctrl_if.slave bus
);
   logic            inflight_q, inflight_d;
   gnt_e            last_gnt_q, last_gnt_d;
   occ_t            occ;
   logic [BITS-1:0] head_data;
   logic            rsp_valid;
   logic            pop;
   logic [2:0]      credit;
   logic            rd_ok;
   logic            rd_elig;
   logic            wr_elig;
   logic            grant_rd;
   logic            grant_wr;

   // RSTB gates eligibility so no handshake or macro access can occur in reset.
   always_comb begin
      rsp_valid  = (occ != '0);
      pop        = rsp_valid & bus.rsp_ready;
      credit     = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
      rd_ok      = (credit < 3'd2);
      rd_elig    = bus.rd_valid & rd_ok & RSTB;
      wr_elig    = bus.wr_valid & RSTB;
      grant_rd   = rd_elig & (~wr_elig | (last_gnt_q == GNT_WR));
      grant_wr   = wr_elig & ~grant_rd;
      inflight_d = grant_rd;
      last_gnt_d = last_gnt_q;
      if (rd_elig && wr_elig) begin
         last_gnt_d = grant_rd ? GNT_RD : GNT_WR;
      end
   end

   always_comb begin
      bus.sram_ceb = 1'b1;
      bus.sram_web = 1'b1;
      bus.sram_a   = '0;
      bus.sram_d   = '0;
      if (grant_wr) begin
         bus.sram_ceb = 1'b0;
         bus.sram_web = 1'b0;
         bus.sram_a   = bus.wr_addr;
         bus.sram_d   = bus.wr_data;
      end else if (grant_rd) begin
         bus.sram_ceb = 1'b0;
         bus.sram_a   = bus.rd_addr;
      end
   end

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         inflight_q <= 1'b0;
         last_gnt_q <= GNT_WR;
      end else begin
         inflight_q <= inflight_d;
         last_gnt_q <= last_gnt_d;
      end
   end

   // sram_q is only meaningful the cycle after a read enable.
   sram_rsp_fifo2 #(.BITS(BITS)) u_rsp_fifo (
      .CLK       (CLK),
      .RSTB      (RSTB),
      .push      (inflight_q),
      .push_data (bus.sram_q),
      .pop       (pop),
      .occ       (occ),
      .head_data (head_data)
   );

   assign bus.wr_ready  = grant_wr;
   assign bus.rd_ready  = grant_rd;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_data  = head_data;
endmodule

// File: tb/tb_sram_1p_ctrl.sv
// Scoreboard bench for sram_1p_ctrl with a behavioural single-port macro model.
module tb_sram_1p_ctrl;
   import sram_ctrl_pkg::*;

   localparam int BITS  = BITS_DEF;
   localparam int DEPTH = DEPTH_DEF;
   localparam int AW    = AW_DEF;

   logic CLK  = 1'b0;
   logic RSTB = 1'b0;
   always #5 CLK = ~CLK;

   sram_1p_ctrl_if #(.BITS(BITS), .AW(AW)) bus ();

   sram_1p_ctrl #(.BITS(BITS), .DEPTH(DEPTH), .AW(AW)) dut (
      .CLK  (CLK),
      .RSTB (RSTB),
      .bus  (bus)
   );

   int checks   = 0;
   int failures = 0;

   logic [BITS-1:0] smem    [DEPTH] = '{default: '0};
   logic [BITS-1:0] ref_mem [DEPTH] = '{default: '0};
   logic [BITS-1:0] exp_q [$];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
      end
   endtask

   // Macro model: registered read data, random garbage on sram_q otherwise.
   always @(posedge CLK) begin
      if (!bus.sram_ceb && !bus.sram_web) smem[bus.sram_a] <= bus.sram_d;
      if (!bus.sram_ceb && bus.sram_web) bus.sram_q <= smem[bus.sram_a];
      else bus.sram_q <= BITS'($urandom);
   end

   logic                 hold_v = 1'b0;
   logic [BITS-1:0]      hold_d;
   logic [AW+BITS+1:0]   exp_mac;

   always @(negedge CLK) begin
      if (!RSTB) begin
         exp_q.delete();
         hold_v = 1'b0;
      end else begin
         exp_mac = {1'b1, 1'b1, AW'(0), BITS'(0)};
         if (bus.wr_ready) exp_mac = {1'b0, 1'b0, bus.wr_addr, bus.wr_data};
         else if (bus.rd_ready) exp_mac = {1'b0, 1'b1, bus.rd_addr, BITS'(0)};
         chk("macro_drive", 32'({bus.sram_ceb, bus.sram_web, bus.sram_a, bus.sram_d}), 32'(exp_mac));
         chk("grant_onehot", 32'(bus.wr_ready & bus.rd_ready), 32'd0);
         chk("ready_wo_valid", 32'((bus.wr_ready & ~bus.wr_valid) | (bus.rd_ready & ~bus.rd_valid)), 32'd0);
         if (hold_v) begin
            chk("rsp_hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("rsp_hold_data", 32'(bus.rsp_data), 32'(hold_d));
         end
         if (bus.rd_valid && bus.rd_ready) exp_q.push_back(ref_mem[bus.rd_addr]);
         if (bus.wr_valid && bus.wr_ready) ref_mem[bus.wr_addr] = bus.wr_data;
         if (bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) chk("rsp_spurious", 32'(bus.rsp_valid), 32'd0);
            else chk("rsp_data", 32'(bus.rsp_data), 32'(exp_q.pop_front()));
         end
         hold_v = bus.rsp_valid & ~bus.rsp_ready;
         hold_d = bus.rsp_data;
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_in();
      bus.wr_valid  = 1'b0;
      bus.rd_valid  = 1'b0;
      bus.rsp_ready = 1'b1;
   endtask

   task automatic drain(input string tag);
      idle_in();
      for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(posedge CLK);
      chk(tag, 32'(exp_q.size()), 32'd0);
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p;
      logic wacc, racc;
      bus.wr_valid  = 1'b1;
      bus.rd_valid  = 1'b1;
      bus.wr_addr   = '0;
      bus.wr_data   = '1;
      bus.rd_addr   = '0;
      bus.rsp_ready = 1'b1;
      repeat (2) @(negedge CLK);
      chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
      chk("rst_rd_ready", 32'(bus.rd_ready), 32'd0);
      chk("rst_ceb", 32'(bus.sram_ceb), 32'd1);
      chk("rst_web", 32'(bus.sram_web), 32'd1);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
      step();
      RSTB = 1'b1;

      // Contested requests from reset alternate starting with the read.
      for (int i = 0; i < 6; i++) begin
         bus.wr_addr = AW'(10 + i);
         bus.wr_data = BITS'(i % 4);
         bus.rd_addr = AW'(20 + i);
         @(negedge CLK);
         chk("rr_rd", 32'(bus.rd_ready), 32'(i % 2 == 0));
         chk("rr_wr", 32'(bus.wr_ready), 32'(i % 2 == 1));
         chk("rr_ceb", 32'(bus.sram_ceb), 32'd0);
         step();
      end
      drain("rr_drain");

      // Write then read the same address on the next cycle.
      bus.wr_valid = 1'b1;
      bus.wr_addr  = AW'(5);
      bus.wr_data  = 2'b10;
      @(negedge CLK);
      chk("raw_wr_acc", 32'(bus.wr_ready), 32'd1);
      step();
      bus.wr_valid = 1'b0;
      bus.rd_valid = 1'b1;
      bus.rd_addr  = AW'(5);
      @(negedge CLK);
      chk("raw_rd_acc", 32'(bus.rd_ready), 32'd1);
      step();
      bus.rd_valid = 1'b0;
      @(negedge CLK);
      chk("raw_lat_early", 32'(bus.rsp_valid), 32'd0);
      step();
      @(negedge CLK);
      chk("raw_lat_2", 32'(bus.rsp_valid), 32'd1);
      chk("raw_data", 32'(bus.rsp_data), 32'd2);
      step();
      drain("raw_drain");

      // Preload i%4 then stream 8 back-to-back reads.
      for (int i = 0; i < 8; i++) begin
         bus.wr_valid = 1'b1;
         bus.wr_addr  = AW'(i);
         bus.wr_data  = BITS'(i % 4);
         @(negedge CLK);
         chk("pre_wr_acc", 32'(bus.wr_ready), 32'd1);
         step();
      end
      bus.wr_valid = 1'b0;
      for (int k = 0; k < 10; k++) begin
         bus.rd_valid = (k < 8);
         bus.rd_addr  = AW'(k % 8);
         @(negedge CLK);
         if (k < 8) chk("b2b_rd_acc", 32'(bus.rd_ready), 32'd1);
         chk("b2b_rsp_valid", 32'(bus.rsp_valid), 32'(k >= 2));
         step();
      end
      drain("b2b_drain");

      // Backpressure: two reads accepted, then credit stalls until rsp_ready returns.
      p = 0;
      bus.rsp_ready = 1'b0;
      bus.rd_valid  = 1'b1;
      for (int c = 0; c < 14; c++) begin
         if (c == 6) bus.rsp_ready = 1'b1;
         bus.rd_addr = AW'((p + 1) % 8);
         @(negedge CLK);
         if (c < 6) chk("bp_rd_ready", 32'(bus.rd_ready), 32'(c < 2));
         if (c >= 2 && c < 6) chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         if (bus.rd_ready) p++;
         if (c == 5) chk("bp_accepts", 32'(p), 32'd2);
         step();
      end
      drain("bp_drain");

      // Reset the cycle after a read grant, with one response buffered.
      bus.rsp_ready = 1'b0;
      bus.rd_valid  = 1'b1;
      bus.rd_addr   = AW'(1);
      @(negedge CLK);
      chk("mid_rd0", 32'(bus.rd_ready), 32'd1);
      step();
      bus.rd_addr = AW'(2);
      @(negedge CLK);
      chk("mid_rd1", 32'(bus.rd_ready), 32'd1);
      step();
      bus.wr_valid = 1'b1;
      RSTB = 1'b0;
      #1;
      chk("mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("mid_ceb", 32'(bus.sram_ceb), 32'd1);
      chk("mid_rd_ready", 32'(bus.rd_ready), 32'd0);
      chk("mid_wr_ready", 32'(bus.wr_ready), 32'd0);
      step();
      step();
      idle_in();
      RSTB = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge CLK);
         chk("mid_no_rsp", 32'(bus.rsp_valid), 32'd0);
         step();
      end

      // Idle with random sram_q: no macro access, nothing reaches rsp_data.
      for (int c = 0; c < 20; c++) begin
         @(negedge CLK);
         chk("idle_ceb", 32'(bus.sram_ceb), 32'd1);
         chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
         chk("idle_rsp_data", 32'(bus.rsp_data), 32'd0);
         step();
      end

      // Random mixed traffic; the scoreboard checks data and ordering.
      wacc = 1'b1;
      racc = 1'b1;
      for (int c = 0; c < 300; c++) begin
         if (wacc || !bus.wr_valid) begin
            bus.wr_valid = 1'($urandom_range(0, 1));
            bus.wr_addr  = AW'($urandom_range(0, 15));
            bus.wr_data  = BITS'($urandom);
         end
         if (racc || !bus.rd_valid) begin
            bus.rd_valid = 1'($urandom_range(0, 1));
            bus.rd_addr  = AW'($urandom_range(0, 15));
         end
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
         @(negedge CLK);
         wacc = bus.wr_ready;
         racc = bus.rd_ready;
         step();
      end
      drain("final_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sram_1p_ctrl.md
SRAM_1P_CTRL -- requirements
Module: sram_1p_ctrl

Interface
REQ-001 SHALL have parameters: BITS, 2, data width; DEPTH, 64, words; AW, 6, address width (DEPTH = 2**AW).
REQ-002 SHALL have ports, one per line:
  CLK  in  1  single clock, all state on rising edge
  RSTB  in  1  asynchronous active-low reset
  wr_valid  in  1  write request
  wr_ready  out  1  write accepted this cycle
  wr_addr  in  AW  write address
  wr_data  in  BITS  write data
  rd_valid  in  1  read request
  rd_ready  out  1  read accepted this cycle
  rd_addr  in  AW  read address
  rsp_valid  out  1  read response available
  rsp_ready  in  1  consumer takes response
  rsp_data  out  BITS  read response data
  sram_ceb  out  1  macro chip enable, active low
  sram_web  out  1  macro write enable, active low (1 = read)
  sram_a  out  AW  macro address
  sram_d  out  BITS  macro write data
  sram_q  in  BITS  macro read data, valid only the cycle after a read enable
REQ-003 SHALL use one clock, CLK; reset RSTB is asynchronous and active-low.

Function
REQ-004 SHALL issue at most one macro access per cycle; a transfer occurs when valid and ready are both high.
REQ-005 SHALL drive the macro combinationally from the granted request: write gives ceb=0, web=0, a=wr_addr, d=wr_data; read gives ceb=0, web=1, a=rd_addr, d=0; no grant gives ceb=1, web=1, a=0, d=0.
REQ-006 SHALL compute read credit as rd_ok = (occ + inflight - pop) < 2, where occ is response-buffer occupancy (0..2), inflight is 1 if a read was granted last cycle, and pop = rsp_valid & rsp_ready.
REQ-007 SHALL arbitrate round-robin when wr_valid and rd_ok&rd_valid are both high: grant the side not granted on the last contested cycle; otherwise grant whichever side is eligible.
REQ-008 SHALL deassert rd_ready when rd_ok=0, regardless of rd_valid.
REQ-009 SHALL sample sram_q only in the cycle after a read grant and push it into the response buffer; sram_q SHALL be ignored in all other cycles.
REQ-010 SHALL implement the response buffer as a 2-entry FIFO; rsp_valid=(occ!=0), rsp_data=head entry.
  - Read-accept to rsp_valid latency is 2 cycles.
  - Responses are returned in request order.
REQ-011 SHALL keep rsp_data and rsp_valid stable while rsp_valid=1 and rsp_ready=0.
REQ-012 SHALL handle a simultaneous push and pop with occ unchanged; the buffer SHALL never overflow (guaranteed by REQ-006).
REQ-013 SHALL return the new data for a read granted the cycle after a write to the same address, relying on macro write-before-read ordering; no extra hazard logic is required.
REQ-014 SHALL sustain one read per cycle with rsp_ready held 1, and one write per cycle with no reads pending.

Reset
REQ-015 SHALL, while RSTB=0, force the following regardless of request inputs:
  - occ=0, inflight=0, rsp_valid=0, rsp_data=0
  - last-contested-grant=write (the first contested cycle grants the read)
  - wr_ready=0, rd_ready=0, sram_ceb=1, sram_web=1
REQ-016 SHALL discard any in-flight read and all buffered responses when reset is asserted mid-operation; no response SHALL appear after reset release without a new request.

Structure
REQ-017 SHALL place the default BITS/DEPTH/AW constants and the 2-bit occupancy type in a shared package, sram_ctrl_pkg.
REQ-018 SHALL use one sub-module: sram_rsp_fifo2 (2-entry FIFO, push/pop/occ). Arbitration and macro drive SHALL stay in the top level.

Verification
REQ-019 Write 2'b10 to addr 5, then read addr 5 on the next cycle -> rsp_data=2'b10, rsp_valid 2 cycles after read accept.
REQ-020 rd_valid=1 on 8 consecutive cycles, addrs 0..7 preloaded with i%4, rsp_ready=1 -> 8 responses on consecutive cycles, in order.
REQ-021 rsp_ready=0 with continuous reads -> exactly 2 reads accepted, then rd_ready=0; rsp_data stable; after rsp_ready=1 reads resume with no loss.
REQ-022 wr_valid and rd_valid both held 1 for 6 cycles after reset -> grants alternate R,W,R,W,R,W; sram_ceb=0 every cycle.
REQ-023 Assert RSTB=0 the cycle after a read grant -> rsp_valid=0, sram_ceb=1 immediately; no response after release.
REQ-024 No requests -> sram_ceb=1 every cycle; random sram_q values never appear on rsp_data.
